// File: rtl/io_input_reader_pkg.sv
// -----------------------------------------------------------------------------
// io_input_reader_pkg
// Shared IO-bus constants for the input reader peripheral: register offsets
// within the IO window, the IO window base used by the upstream address
// decoder, and a small offset-decode helper.
// -----------------------------------------------------------------------------
package io_input_reader_pkg;

    // IO window placement, consumed by the bus-level decoder in front of the
    // peripherals. The reader itself only compares addr[11:0].
    localparam logic [31:0] IO_BASE = 32'hFFFF_F000;
    localparam logic [31:0] IO_SIZE = 32'h0000_1000;

    localparam logic [11:0] ADDR_SW  = 12'h070;
    localparam logic [11:0] ADDR_BTN = 12'h078;
    localparam logic [11:0] ADDR_EVT = 12'h07C;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_SW,
        REG_BTN,
        REG_EVT
    } io_reg_e;

    function automatic io_reg_e decode_offset(input logic [11:0] off);
        case (off)
            ADDR_SW:  return REG_SW;
            ADDR_BTN: return REG_BTN;
            ADDR_EVT: return REG_EVT;
            default:  return REG_NONE;
        endcase
    endfunction

    function automatic logic io_hit(input logic [31:0] a);
        return (a >= IO_BASE) && ((a - IO_BASE) < IO_SIZE);
    endfunction

endpackage

// File: rtl/io_input_reader_debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
// Two-flop synchroniser plus tick-sampled debouncer for a bank of W inputs.
// A level is accepted into dout only after it is seen on two consecutive
// ticks, so pulses shorter than one tick period never get through.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-low reset
//   tick  one-cycle sample strobe shared across banks
//   din   raw asynchronous inputs
//   dout  debounced, registered levels
// -----------------------------------------------------------------------------
module debounce_bank #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] r_sync1;
    logic [W-1:0] r_sync2;
    logic [W-1:0] r_prev;
    logic [W-1:0] r_stable;
    logic [W-1:0] w_agree;

    // Bits whose current sample matches the previous tick's sample.
    assign w_agree = ~(r_sync2 ^ r_prev);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_stable <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            if (tick) begin
                r_prev   <= r_sync2;
                r_stable <= (r_sync2 & w_agree) | (r_stable & ~w_agree);
            end
        end
    end

    assign dout = r_stable;

endmodule

// File: rtl/io_input_reader.sv
// -----------------------------------------------------------------------------
// io_input_reader
// Read-side IO peripheral: debounced switches, debounced buttons and sticky
// button-press event flags (write-1-to-clear), returned on bus reads.
//
// Ports:
//   clk    system clock
//   rst    synchronous active-low reset
//   addr   bus address, only addr[11:0] is decoded
//   ren    bus read enable
//   wen    bus write enable
//   wdata  bus write data, W1C mask at ADDR_EVT
//   sw     raw switch pins
//   btn    raw button pins, active-high
//   rdata  combinational read data, 0 when not reading a mapped register
//   irq    high while any event flag is set
// -----------------------------------------------------------------------------
module io_input_reader
    import io_input_reader_pkg::*;
#(
    parameter int SW_W       = 24,
    parameter int BTN_W      = 5,
    parameter int DEB_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    input  logic             ren,
    input  logic             wen,
    input  logic [31:0]      wdata,
    input  logic [SW_W-1:0]  sw,
    input  logic [BTN_W-1:0] btn,
    output logic [31:0]      rdata,
    output logic             irq
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;
    logic [SW_W-1:0]  w_sw_stable;
    logic [BTN_W-1:0] w_btn_stable;
    logic [BTN_W-1:0] r_btn_stable_d;
    logic [BTN_W-1:0] r_evt;
    logic [BTN_W-1:0] w_evt_set;
    logic [BTN_W-1:0] w_evt_clr;
    io_reg_e          w_sel;
    logic             w_unused_bits;

    assign w_tick = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    debounce_bank #(.W(SW_W)) u_sw_deb (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick),
        .din  (sw),
        .dout (w_sw_stable)
    );

    debounce_bank #(.W(BTN_W)) u_btn_deb (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick),
        .din  (btn),
        .dout (w_btn_stable)
    );

    assign w_sel     = decode_offset(addr[11:0]);
    assign w_evt_set = w_btn_stable & ~r_btn_stable_d;
    assign w_evt_clr = (wen && (w_sel == REG_EVT)) ? wdata[BTN_W-1:0] : '0;

    // Set is OR-ed in after the clear so a press landing on a W1C survives.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_btn_stable_d <= '0;
            r_evt          <= '0;
        end else begin
            r_btn_stable_d <= w_btn_stable;
            r_evt          <= (r_evt & ~w_evt_clr) | w_evt_set;
        end
    end

    always_comb begin
        rdata = '0;
        if (ren) begin
            case (w_sel)
                REG_SW:  rdata = 32'(w_sw_stable);
                REG_BTN: rdata = 32'(w_btn_stable);
                REG_EVT: rdata = 32'(r_evt);
                default: rdata = '0;
            endcase
        end
    end

    assign irq = |r_evt;

    // Upper address bits are decoded upstream; upper wdata bits have no target.
    assign w_unused_bits = ^{addr[31:12], wdata[31:BTN_W]};

endmodule

// File: tb/tb_io_input_reader.sv
module tb_io_input_reader;

    localparam int SW_W  = 24;
    localparam int BTN_W = 5;
    localparam int D     = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [31:0]       addr = '0;
    logic              ren = 1'b0;
    logic              wen = 1'b0;
    logic [31:0]       wdata = '0;
    logic [SW_W-1:0]   sw = '0;
    logic [BTN_W-1:0]  btn = '0;
    logic [31:0]       rdata;
    logic              irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    io_input_reader #(.SW_W(SW_W), .BTN_W(BTN_W), .DEB_CYCLES(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .ren   (ren),
        .wen   (wen),
        .wdata (wdata),
        .sw    (sw),
        .btn   (btn),
        .rdata (rdata),
        .irq   (irq)
    );

    // Reference model: pins seen by the sampler lag two edges; a sample is
    // taken every D edges after reset release; a bit is accepted when two
    // consecutive samples agree; a newly accepted button 1 raises its flag on
    // the following edge.
    logic [SW_W-1:0]  m_sw_p1, m_sw_p2, m_sw_last, m_sw_st;
    logic [BTN_W-1:0] m_bt_p1, m_bt_p2, m_bt_last, m_bt_st, m_evt, m_pend;
    int               m_k;

    task automatic m_edge();
        logic [BTN_W-1:0] clr;
        if (!rst) begin
            m_sw_p1 = '0; m_sw_p2 = '0; m_sw_last = '0; m_sw_st = '0;
            m_bt_p1 = '0; m_bt_p2 = '0; m_bt_last = '0; m_bt_st = '0;
            m_evt = '0; m_pend = '0; m_k = 0;
        end else begin
            clr = (wen && addr[11:0] == 12'h07C) ? wdata[BTN_W-1:0] : '0;
            m_evt  = (m_evt & ~clr) | m_pend;
            m_pend = '0;
            if (m_k % D == D - 1) begin
                for (int b = 0; b < SW_W; b++)
                    if (m_sw_p2[b] == m_sw_last[b]) m_sw_st[b] = m_sw_p2[b];
                m_sw_last = m_sw_p2;
                for (int b = 0; b < BTN_W; b++)
                    if (m_bt_p2[b] == m_bt_last[b]) begin
                        if (m_bt_p2[b] && !m_bt_st[b]) m_pend[b] = 1'b1;
                        m_bt_st[b] = m_bt_p2[b];
                    end
                m_bt_last = m_bt_p2;
            end
            m_sw_p2 = m_sw_p1; m_sw_p1 = sw;
            m_bt_p2 = m_bt_p1; m_bt_p1 = btn;
            m_k++;
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [31:0] a, input logic r);
        if (!r) return '0;
        case (a[11:0])
            12'h070: return {8'h0, m_sw_st};
            12'h078: return {27'h0, m_bt_st};
            12'h07C: return {27'h0, m_evt};
            default: return '0;
        endcase
    endfunction

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [11:0] off, output logic [31:0] v);
        logic [31:0] r;
        r = $urandom();
        addr = {r[31:12], off};
        ren = 1'b1;
        #1;
        v = rdata;
        ren = 1'b0;
    endtask

    // One clock edge, then compare irq and every register view against the model.
    task automatic cycle(input string tag);
        logic [31:0] sa, sd, v, r;
        logic sr, sw_en;
        @(posedge clk);
        m_edge();
        #1;
        sa = addr; sr = ren; sw_en = wen; sd = wdata;
        cmp({tag, "_irq"}, {31'b0, irq}, {31'b0, |m_evt});
        wen = 1'b0;
        rd(12'h070, v); cmp({tag, "_sw"}, v, exp_read(32'h070, 1'b1));
        rd(12'h078, v); cmp({tag, "_btn"}, v, exp_read(32'h078, 1'b1));
        rd(12'h07C, v); cmp({tag, "_evt"}, v, exp_read(32'h07C, 1'b1));
        r = $urandom();
        addr = r; ren = r[12];
        #1;
        cmp({tag, "_any"}, rdata, exp_read(r, r[12]));
        addr = sa; ren = sr; wen = sw_en; wdata = sd;
    endtask

    task automatic bus_wr(input logic [11:0] off, input logic [31:0] d, input string tag);
        addr = {20'hFFFFF, off}; wdata = d; wen = 1'b1;
        cycle(tag);
        wen = 1'b0;
    endtask

    logic [31:0] v;
    logic [31:0] r;
    int          first;
    logic        coll;

    initial begin
        // 1: reset with switches high, then qualification latency
        sw = '1; rst = 1'b0;
        repeat (3) cycle("t1_rst");
        rst = 1'b1;
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            cycle("t1_rel");
            rd(12'h070, v);
            if (first == 0 && v == 32'h00FF_FFFF) first = i;
        end
        cmp("t1_latency_in_window", {31'b0, (first >= 7 && first <= 11)}, 32'h1);

        // 2: short glitch never qualifies
        btn[2] = 1'b1;
        repeat (3) cycle("t2_hi");
        btn[2] = 1'b0;
        repeat (20) cycle("t2_lo");
        rd(12'h07C, v); cmp("t2_evt_zero", v, 32'h0);

        // 3: press and release
        btn[0] = 1'b1;
        repeat (20) cycle("t3_press");
        rd(12'h078, v); cmp("t3_btn_level", v, 32'h01);
        btn[0] = 1'b0;
        repeat (20) cycle("t3_release");
        rd(12'h078, v); cmp("t3_btn_released", v, 32'h00);
        rd(12'h07C, v); cmp("t3_evt_sticky", v, 32'h01);
        cmp("t3_irq_sticky", {31'b0, irq}, 32'h1);

        // 4: W1C and ignored writes
        btn[2] = 1'b1;
        repeat (20) cycle("t4_press2");
        btn[2] = 1'b0;
        repeat (20) cycle("t4_rel2");
        rd(12'h07C, v); cmp("t4_evt_05", v, 32'h05);
        bus_wr(12'h07C, 32'h4, "t4_w1c4");
        rd(12'h07C, v); cmp("t4_evt_01", v, 32'h01);
        cmp("t4_irq_on", {31'b0, irq}, 32'h1);
        bus_wr(12'h07C, 32'h1, "t4_w1c1");
        rd(12'h07C, v); cmp("t4_evt_00", v, 32'h00);
        cmp("t4_irq_off", {31'b0, irq}, 32'h0);
        btn[1] = 1'b1;
        repeat (20) cycle("t4_press1");
        btn[1] = 1'b0;
        repeat (20) cycle("t4_rel1");
        bus_wr(12'h070, 32'hFFFF_FFFF, "t4_wr_sw");
        bus_wr(12'h078, 32'hFFFF_FFFF, "t4_wr_btn");
        bus_wr(12'h07D, 32'hFFFF_FFFF, "t4_wr_unmapped");
        rd(12'h07C, v); cmp("t4_evt_kept", v, 32'h02);
        bus_wr(12'h07C, 32'h1F, "t4_clear_all");

        // 5: press lands on a W1C of the same bit
        addr = 32'hFFFF_F07C; wdata = 32'h8; wen = 1'b1;
        btn[3] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            coll = m_pend[3];
            cycle("t5_coll");
            if (coll) begin
                rd(12'h07C, v);
                cmp("t5_set_wins", {31'b0, v[3]}, 32'h1);
            end
        end
        wen = 1'b0;
        btn[3] = 1'b0;
        repeat (12) cycle("t5_rel");

        // 6: decode corners
        sw = 24'hA5A5A5;
        repeat (12) cycle("t6_sw");
        addr = 32'h0000_0074; ren = 1'b1; #1;
        cmp("t6_unmapped", rdata, 32'h0);
        addr = 32'h0000_0078; ren = 1'b0; #1;
        cmp("t6_ren_low", rdata, 32'h0);
        addr = 32'hFFFF_F070; ren = 1'b1; #1;
        cmp("t6_sw_a5", rdata, 32'h00A5_A5A5);
        ren = 1'b0;

        // Random traffic with occasional mid-debounce resets
        for (int i = 0; i < 500; i++) begin
            r = $urandom();
            if (r[3:0] == 4'd0) sw = SW_W'($urandom());
            if (r[6:4] == 3'd0) btn = btn ^ BTN_W'(1 << $urandom_range(0, BTN_W - 1));
            rst = (r[15:10] != 6'd0);
            wen = 1'b0;
            case (r[18:16])
                3'd0: begin addr = 32'hFFFF_F07C; wdata = $urandom(); wen = 1'b1; end
                3'd1: begin addr = 32'hFFFF_F070; wdata = $urandom(); wen = 1'b1; end
                3'd2: begin addr = {20'hFFFFF, 4'h0, 4'h7, r[23:20]}; wdata = $urandom(); wen = 1'b1; end
                default: ;
            endcase
            cycle("rnd");
        end
        rst = 1'b1; wen = 1'b0;
        repeat (4) cycle("rnd_tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_input_reader.md
Name: io_input_reader

Overview:
Memory-mapped input peripheral on the IO bus: the read-side counterpart of the write-only display peripheral.
- Synchronises and debounces 24 slide switches and 5 push buttons.
- Latches button-press events in a sticky flag register that software clears.
- Returns all three views to the CPU on bus reads.
- Sits beside the display/LED peripherals behind the IO address decoder.

Parameters:
SW_W, 24, number of switch inputs
BTN_W, 5, number of button inputs
DEB_CYCLES, 100000, clk cycles between debounce sample ticks (>=2)
ADDR_SW, 12'h070, switch register offset (addr[11:0])
ADDR_BTN, 12'h078, debounced button level register offset
ADDR_EVT, 12'h07C, button event flag register offset (W1C)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
addr  in  32  bus address; only addr[11:0] compared
ren  in  1  bus read enable
wen  in  1  bus write enable
wdata  in  32  bus write data (used only for W1C at ADDR_EVT)
sw  in  SW_W  raw asynchronous switch pins
btn  in  BTN_W  raw asynchronous button pins, active-high
rdata  out  32  read data
irq  out  1  high while any event flag is set

Behaviour:
- Reset (rst==0 at posedge clk): sync stages, sample regs, stable regs, evt flags and tick counter are all 0. irq=0. rdata=0 because ren is ignored only via decode; rdata is 0 whenever ren==0.
- Synchroniser: 2 flip-flop stages per input bit.
- Tick: counter runs 0..DEB_CYCLES-1 and wraps. tick=1 for one cycle when count==DEB_CYCLES-1.
- Debounce, on tick only:
  - prev <= sync.
  - For each bit where sync==prev, stable <= sync.
  - A level must be seen on two consecutive ticks before it is accepted.
  - A pulse shorter than DEB_CYCLES cycles never reaches stable.
  - Accepted change appears in stable within 2*DEB_CYCLES+3 cycles of the pin change.
- Event flags:
  - evt[i] sets on a rising edge of btn_stable[i] (stable 0->1, registered compare).
  - Falling edges are ignored.
  - W1C: wen && addr[11:0]==ADDR_EVT clears evt[i] where wdata[i]==1.
  - Same-cycle set and clear on one bit: set wins.
  - Flags hold until cleared; multiple presses collapse into one flag.
- Writes to ADDR_SW or ADDR_BTN, or to unmapped offsets, are ignored.
- Read: combinational, zero latency, from registered state.
  - ren && ADDR_SW -> {zero-extend, sw_stable}
  - ren && ADDR_BTN -> {zero-extend, btn_stable}
  - ren && ADDR_EVT -> {zero-extend, evt}
  - anything else -> 0
  - Reads have no side effects.
- irq = |evt, registered-state derived, no extra latency.
- Reset mid-debounce discards partial samples; stable returns to 0 and must re-qualify after reset release.

Decomposition:
- Shared IO package holds ADDR_SW/ADDR_BTN/ADDR_EVT and the IO base-address constants used by the bus decoder.
- Sub-module debounce_bank:
  - parameter W; ports clk, rst, tick, din[W], dout[W].
  - contains the synchroniser, prev and stable registers.
  - Two instances: SW_W and BTN_W, sharing one tick generator in the top.

Test Plan (DEB_CYCLES=4):
1. Reset: hold rst=0 for 3 cycles with sw=24'hFFFFFF -> rdata=0 on all reads, irq=0. After release, sw reads 24'hFFFFFF within 11 cycles, not earlier than 7.
2. Glitch reject: btn[2] high for 3 cycles then low -> btn register stays 0, evt stays 0, irq stays 0 for 20 cycles.
3. Press/event: btn[0] held high 20 cycles then released -> btn reads 5'h01 then 5'h00; evt reads 5'h01 and irq=1 persists after release.
4. W1C: evt=5'h05, write wdata=32'h4 to ADDR_EVT -> evt reads 5'h01, irq=1. Write 32'h1 -> evt=0, irq=0. Write to ADDR_SW -> no state change.
5. Set/clear collision: btn_stable[3] rises in the same cycle as a W1C with wdata=32'h8 -> evt[3]=1 after that cycle.
6. Address decode: ren=1 at 12'h074 and at ADDR_BTN with ren=0 -> rdata=0. addr=32'hFFFF_F070 with sw stable 24'hA5A5A5 -> rdata=32'h00A5A5A5.
